// File: rtl/string_hw_seq.sv
// string_hw_seq: multi-mode byte-serial string coprocessor.
// Compare, case conversion and find-char over up to MAX_LEN bytes.
module string_hw_seq #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [2:0]           index,
  input  logic [8*MAX_LEN-1:0] A,
  input  logic [8*MAX_LEN-1:0] B,
  input  logic [LEN_W-1:0]     lengthA,
  input  logic [LEN_W-1:0]     lengthB,
  output logic                 done,
  output logic                 busy,
  output logic                 error,
  output logic [8*MAX_LEN-1:0] result,
  output logic [LEN_W-1:0]     count
);

  localparam int W = 8 * MAX_LEN;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     ra;
  logic [W-1:0]     rb;
  logic [LEN_W-1:0] rla;
  logic [LEN_W-1:0] rlb;
  logic [2:0]       ridx;
  logic [LEN_W-1:0] p;

  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [7:0] nb;
  logic       is_up;
  logic       is_lo;
  logic       last;
  logic       bad;

  // Select byte p of the latched operands.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (p == LEN_W'(k)) begin
        a_byte = ra[8*(MAX_LEN-1-k) +: 8];
        b_byte = rb[8*(MAX_LEN-1-k) +: 8];
      end
    end
  end

  // Per-byte case transform for modes 1-3.
  always_comb begin
    is_up = (a_byte >= 8'h41) && (a_byte <= 8'h5a);
    is_lo = (a_byte >= 8'h61) && (a_byte <= 8'h7a);
    nb    = a_byte;
    unique case (ridx)
      3'd1:    if (is_lo) nb = a_byte - 8'd32;
      3'd2:    if (is_up) nb = a_byte + 8'd32;
      3'd3:    if (is_up || is_lo) nb = a_byte ^ 8'h20;
      default: nb = a_byte;
    endcase
  end

  // Latch-time validity check and last-byte detect.
  always_comb begin
    last = (p == rla - LEN_W'(1));
    bad  = (index > 3'd4)
        || (lengthA > LEN_W'(MAX_LEN))
        || ((index == 3'd0) && (lengthB > LEN_W'(MAX_LEN)));
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rla    <= '0;
      rlb    <= '0;
      ridx   <= '0;
      p      <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
      count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          ra     <= A;
          rb     <= B;
          rla    <= lengthA;
          rlb    <= lengthB;
          ridx   <= index;
          p      <= '0;
          result <= '0;
          count  <= '0;
          error  <= 1'b0;
          if (bad) begin
            error <= 1'b1;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (lengthA == '0) begin
            if (index == 3'd0) result <= W'(lengthB == '0);
            if (index == 3'd4) count <= '1;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          p     <= p + LEN_W'(1);
          count <= count + LEN_W'(1);
          unique case (ridx)
            3'd0: begin
              if (rla != rlb) begin
                count <= '0;
                state <= DONE;
              end else if (a_byte != b_byte) begin
                count <= p;
                state <= DONE;
              end else if (last) begin
                result <= W'(1);
                state  <= DONE;
              end
            end
            3'd4: begin
              if (a_byte == rb[W-1 -: 8]) begin
                count <= p;
                state <= DONE;
              end else if (last) begin
                count <= '1;
                state <= DONE;
              end
            end
            default: begin
              for (int k = 0; k < MAX_LEN; k++) begin
                if (p == LEN_W'(k)) result[8*(MAX_LEN-1-k) +: 8] <= nb;
              end
              if (last) state <= DONE;
            end
          endcase
          if ((ridx == 3'd0 && (rla != rlb || a_byte != b_byte)) ||
              (ridx == 3'd4 && a_byte == rb[W-1 -: 8]) || last) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          if (!go) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
